// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic chain of STAGES register slots carrying a WIDTH-bit payload with a
//   valid/ready handshake on both sides. Supports backpressure, per-slot flush
//   and two saturating performance counters.
//
// Ports
//   clk, rst               rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake, in_data payload
//   out_valid/out_ready    downstream handshake, out_data payload (slot STAGES-1)
//   flush, flush_mask      squash the masked slots at the next edge
//   clr_cnt                synchronous clear of both counters
//   occupancy              registered number of valid slots
//   stall_cnt              cycles with out_valid=1 and out_ready=0
//   bubble_cnt             cycles with out_ready=1 and out_valid=0
module pipe_stage_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    input  logic [STAGES-1:0]            flush_mask,
    input  logic                         clr_cnt,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam int unsigned OccW = $clog2(STAGES + 1);

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [STAGES-1:0]            ready;
    logic [OccW-1:0]              occ_q, occ_d;
    logic [CNT_W-1:0]             stall_q, stall_d;
    logic [CNT_W-1:0]             bubble_q, bubble_d;

    // ready[i]: whatever sits in slot i may move on this cycle. Written as
    // "out_ready or any downstream hole" to avoid a self-referencing vector.
    always_comb begin
        ready = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            logic r;
            r = out_ready;
            for (int j = i + 1; j < int'(STAGES); j++) begin
                if (!valid_q[j]) r = 1'b1;
            end
            ready[i] = r;
        end
    end

    assign in_ready  = !valid_q[0] || ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;

        // A slot reloads from its upstream neighbour whenever it is empty or
        // its own content leaves; an invalid upstream leaves it empty.
        if (!valid_q[0] || ready[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) data_d[0] = in_data;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            if (!valid_q[i] || ready[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) data_d[i] = data_q[i-1];
            end
        end

        // Flush overrides whatever would move into a masked slot.
        if (flush) valid_d = valid_d & ~flush_mask;

        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OccW'(valid_d[i]);
        end
    end

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (clr_cnt) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + 1'b1;
            end
            if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_d = bubble_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            data_q   <= '0;
            occ_q    <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign occupancy  = occ_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule
